// File: rtl/seq_detect_pkg.sv
// Shared types and default sizes for the programmable serial pattern detector.
package seq_detect_pkg;

  localparam int PW_DEF = 8;
  localparam int LW_DEF = 4;
  localparam int CW_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

endpackage

// File: rtl/seq_detect_if.sv
// Configuration/stream/status bundle between a requester and the pattern detector.
interface seq_detect_if
  import seq_detect_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int LW = LW_DEF,
  parameter int CW = CW_DEF
) ();

  logic          start;
  logic          abort;
  logic [PW-1:0] pattern;
  logic [LW-1:0] pat_len;
  logic          overlap;
  logic [CW-1:0] match_limit;
  logic          x;
  logic          x_valid;
  logic          y;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] match_count;

  modport master (
    output start, abort, pattern, pat_len, overlap, match_limit, x, x_valid,
    input  y, busy, done, err, match_count
  );

  modport slave (
    input  start, abort, pattern, pat_len, overlap, match_limit, x, x_valid,
    output y, busy, done, err, match_count
  );

endinterface

// File: rtl/seq_match_shreg.sv
// Serial history and fill tracking; flags when the newest pat_len bits equal the pattern.
module seq_match_shreg
  import seq_detect_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          shift_i,
  input  logic          clr_fill_i,
  input  logic          clear_i,
  input  logic          x_i,
  input  logic [PW-1:0] pattern_i,
  input  logic [LW-1:0] len_i,
  output logic          hit_o
);

  logic [PW-2:0] hist_q, hist_d;
  logic [LW-1:0] fill_q, fill_d;
  logic [PW-1:0] cand;
  logic [PW-1:0] mask;
  logic [LW:0]   fill_inc;

  assign cand     = {hist_q, x_i};
  assign fill_inc = {1'b0, fill_q} + (LW+1)'(1);

  always_comb begin
    mask = '0;
    for (int i = 0; i < PW; i++) begin
      mask[i] = (i < int'(len_i));
    end
  end

  // Only the low len_i bits take part; upper pattern bits are don't-care.
  assign hit_o = (fill_inc >= {1'b0, len_i}) && (((cand ^ pattern_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_i) begin
      hist_d = cand[PW-2:0];
      if (clr_fill_i) begin
        fill_d = '0;
      end else if (fill_q != LW'(PW)) begin
        fill_d = fill_inc[LW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Controller for the programmable detector: config latch, IDLE/RUN/DONE FSM and match counter.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int LW = LW_DEF,
  parameter int CW = CW_DEF
) (
  input logic         clk,
  input logic         reset,
  seq_detect_if.slave bus
);

  state_e        state_q, state_d;
  logic [PW-1:0] pattern_q, pattern_d;
  logic [LW-1:0] len_q, len_d;
  logic          overlap_q, overlap_d;
  logic [CW-1:0] limit_q, limit_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_inc;
  logic          len_ok;
  logic          hit;
  logic          match;
  logic          accept;
  logic          shift;

  assign len_ok    = (bus.pat_len != '0) && (bus.pat_len <= LW'(PW));
  assign count_inc = count_q + CW'(1);
  assign shift     = (state_q == S_RUN) && bus.x_valid;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    limit_d   = limit_q;
    count_d   = count_q;
    err_d     = 1'b0;
    accept    = 1'b0;
    match     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            accept    = 1'b1;
            pattern_d = bus.pattern;
            len_d     = bus.pat_len;
            overlap_d = bus.overlap;
            limit_d   = bus.match_limit;
            count_d   = '0;
            state_d   = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Abort wins over a coincident match so the count never moves on the way out.
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.x_valid && hit) begin
          match   = 1'b1;
          count_d = count_inc;
          if ((limit_q != '0) && (count_inc == limit_q)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      limit_q   <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  seq_match_shreg #(
    .PW(PW),
    .LW(LW)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .shift_i   (shift),
    .clr_fill_i(match && !overlap_q),
    .clear_i   (accept),
    .x_i       (bus.x),
    .pattern_i (pattern_q),
    .len_i     (len_q),
    .hit_o     (hit)
  );

  assign bus.y           = match;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = err_q;
  assign bus.match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed table plus randomized run against a queue-based reference model of the detector.
module tb_seq_detect_ctrl;

  typedef struct {
    bit       rst;
    bit       start;
    bit       abort;
    bit [7:0] pat;
    bit [3:0] len;
    bit       ovl;
    bit [7:0] lim;
    bit       x;
    bit       xv;
    bit       ey;
    bit       eb;
    bit       ed;
    bit       ee;
    bit [7:0] ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nCompared = 0;
  int   nMismatched = 0;
  vec_t vecs[$];

  // Reference model: bits seen since the last start (or last non-overlap match).
  int       mState = 0;
  bit [7:0] mPat = '0;
  int       mLen = 0;
  bit       mOvl = 1'b0;
  bit [7:0] mLim = '0;
  bit [7:0] mCount = '0;
  bit       mErr = 1'b0;
  bit       mq[$];

  seq_detect_if #(.PW(8), .LW(4), .CW(8)) dut_if ();

  seq_detect_ctrl #(.PW(8), .LW(4), .CW(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dut_if)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit rst, bit st, bit ab, bit [7:0] pat, bit [3:0] len, bit ovl,
                              bit [7:0] lim, bit x, bit xv, bit ey, bit eb, bit ed, bit ee,
                              bit [7:0] ec);
    vec_t v;
    v.rst = rst; v.start = st; v.abort = ab; v.pat = pat; v.len = len; v.ovl = ovl;
    v.lim = lim; v.x = x; v.xv = xv; v.ey = ey; v.eb = eb; v.ed = ed; v.ee = ee; v.ec = ec;
    return v;
  endfunction

  function automatic bit modelHit(bit x);
    if (mq.size() + 1 < mLen) return 1'b0;
    for (int k = 0; k < mLen; k++) begin
      bit b;
      b = (k == mLen - 1) ? x : mq[mq.size() - (mLen - 1) + k];
      if (b != mPat[mLen-1-k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic modelStep(input vec_t v);
    bit errNext;
    bit h;
    errNext = 1'b0;
    if (v.rst) begin
      mState = 0; mPat = '0; mLen = 0; mOvl = 1'b0; mLim = '0; mCount = '0; mErr = 1'b0;
      mq.delete();
      return;
    end
    case (mState)
      0: if (v.start) begin
        if (v.len >= 1 && v.len <= 8) begin
          mPat = v.pat; mLen = int'(v.len); mOvl = v.ovl; mLim = v.lim;
          mCount = '0; mq.delete(); mState = 1;
        end else begin
          errNext = 1'b1;
        end
      end
      1: if (v.abort) begin
        mState = 0;
      end else if (v.xv) begin
        h = modelHit(v.x);
        mq.push_back(v.x);
        if (mq.size() > 8) void'(mq.pop_front());
        if (h) begin
          mCount = mCount + 8'd1;
          if (!mOvl) mq.delete();
          if (mLim != 0 && mCount == mLim) mState = 2;
        end
      end
      default: mState = 0;
    endcase
    mErr = errNext;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset               = v.rst;
    dut_if.start        = v.start;
    dut_if.abort        = v.abort;
    dut_if.pattern      = v.pat;
    dut_if.pat_len      = v.len;
    dut_if.overlap      = v.ovl;
    dut_if.match_limit  = v.lim;
    dut_if.x            = v.x;
    dut_if.x_valid      = v.xv;
    #1;
  endtask

  task automatic compareOne(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input bit ey, input bit eb,
                             input bit ed, input bit ee, input bit [7:0] ec);
    compareOne($sformatf("%s[%0d].y", tag, idx), 32'(dut_if.y), 32'(ey));
    compareOne($sformatf("%s[%0d].busy", tag, idx), 32'(dut_if.busy), 32'(eb));
    compareOne($sformatf("%s[%0d].done", tag, idx), 32'(dut_if.done), 32'(ed));
    compareOne($sformatf("%s[%0d].err", tag, idx), 32'(dut_if.err), 32'(ee));
    compareOne($sformatf("%s[%0d].count", tag, idx), 32'(dut_if.match_count), 32'(ec));
  endtask

  initial begin
    vec_t     v;
    bit [7:0] gPat;
    reset = 1'b1;
    dut_if.start = 1'b0; dut_if.abort = 1'b0; dut_if.pattern = '0; dut_if.pat_len = '0;
    dut_if.overlap = 1'b0; dut_if.match_limit = '0; dut_if.x = 1'b0; dut_if.x_valid = 1'b0;

    // Reset state, then non-overlapping 1001 on stream 1,0,0,1,0,0,1
    vecs.push_back(mk(1,0,0, 8'h00,0,0,0, 0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0, 8'h09,4,0,0, 0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,1,0,0,1));
    // Same stream, overlapping
    vecs.push_back(mk(0,1,0, 8'h09,4,1,0, 0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,1,0,0,2));
    // Limit 2 on pattern 11 with gaps in x_valid
    vecs.push_back(mk(0,1,0, 8'h03,2,1,2, 0,0, 0,0,0,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,1,0,2));
    // Invalid lengths 0 and 9, first on the IDLE cycle right after DONE
    vecs.push_back(mk(0,1,0, 8'h03,0,1,0, 1,1, 0,0,0,0,2));
    vecs.push_back(mk(0,1,0, 8'h03,9,1,0, 0,0, 0,0,0,1,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,1,2));
    // Abort on a matching bit: no pulse, count held
    vecs.push_back(mk(0,1,0, 8'h03,2,1,0, 0,0, 0,0,0,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 1,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,0,0,0,1));
    // Reset mid-run clears the count
    vecs.push_back(mk(0,1,0, 8'h03,2,1,0, 0,0, 0,0,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,1));
    vecs.push_back(mk(1,0,0, 0,0,0,0, 0,0, 0,1,0,0,2));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0));
    // Start while busy with a different pattern is ignored
    vecs.push_back(mk(0,1,0, 8'h05,3,0,0, 0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0, 8'h07,3,1,0, 1,1, 0,1,0,0,0));
    vecs.push_back(mk(0,1,0, 8'h07,3,1,0, 0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 1,1,0,0,0));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 1,1, 0,1,0,0,1));
    vecs.push_back(mk(0,0,1, 0,0,0,0, 0,0, 0,1,0,0,1));
    // Full-width pattern with limit 1
    gPat = 8'hA5;
    vecs.push_back(mk(0,1,0, gPat,8,1,1, 0,0, 0,0,0,0,1));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(0,0,0, 0,0,0,0, gPat[7-k],1, (k == 7),1,0,0,0));
    end
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,1,0,1));
    vecs.push_back(mk(0,0,0, 0,0,0,0, 0,0, 0,0,0,0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput("table", i, vecs[i].ey, vecs[i].eb, vecs[i].ed, vecs[i].ee, vecs[i].ec);
      modelStep(vecs[i]);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = mk((i == 0) || ($urandom_range(0, 199) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 39) == 0), 8'($urandom), 4'($urandom_range(0, 9)),
             1'($urandom), 8'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 3) != 0), 0,0,0,0,0);
      applyStimulus(v);
      checkOutput("rand", i, (mState == 1) && v.xv && !v.abort && modelHit(v.x),
                  (mState == 1), (mState == 2), mErr, mCount);
      modelStep(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Run-time programmable serial pattern detector with controller FSM. Replaces the hard-coded Mealy detectors with one configurable engine. Pattern, pattern length, overlap/non-overlap mode and match limit are latched on a start handshake. Serial bits are consumed on `x_valid`, matches are flagged as a Mealy pulse, matches are counted, and `done` is signalled when the limit is reached.

Parameters:
- PW, 8, maximum pattern width in bits (≥2)
- LW, 4, width of `pat_len` port; must satisfy 2^LW > PW
- CW, 8, width of match counter and `match_limit`

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to latch config and begin; honoured only in IDLE
- abort  input  1  return to IDLE from RUN without asserting done
- pattern  input  PW  pattern; bit[pat_len-1] = first serial bit, bit[0] = last
- pat_len  input  LW  pattern length; valid range 1..PW
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- match_limit  input  CW  matches before done; 0 = unlimited
- x  input  1  serial data bit
- x_valid  input  1  `x` is valid this cycle
- y  output  1  Mealy match: combinational, high in the cycle the final pattern bit is on `x`
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on the limit being reached
- err  output  1  one-cycle pulse: start rejected for invalid `pat_len`
- match_count  output  CW  matches since last accepted start; held after done

Behaviour:
- Reset: state = IDLE. History, fill, `match_count` and latched config are cleared to 0. `y`, `busy`, `done` and `err` are 0.
- States are IDLE, RUN and DONE.
- IDLE
  - start with 1 ≤ `pat_len` ≤ PW: latch `pattern`, `pat_len`, `overlap` and `match_limit`; clear history, fill and `match_count`; go to RUN next cycle.
  - start with `pat_len` = 0 or > PW: `err` = 1 the next cycle; stay in IDLE; `match_count` unchanged.
- RUN
  - Cycles with `x_valid` = 0 are ignored: no shift, `y` = 0.
  - On `x_valid` = 1, candidate = {history, x}, low `pat_len` bits.
  - Match condition: fill + 1 ≥ `pat_len` and candidate == `pattern` (low `pat_len` bits). Bits above `pat_len` are don't-care.
  - `y` = RUN & `x_valid` & match, with no register on the `x`→`y` path.
  - History always shifts `x` in.
  - Fill increments, saturating at PW.
  - On a match in non-overlap mode, fill is cleared to 0 instead; history bits are then unusable until refilled.
  - On a match, `match_count` increments (registered).
  - If `match_limit` ≠ 0 and the new count == `match_limit`: go to DONE.
  - `abort` has priority over a same-cycle match: go to IDLE, `y` = 0, no count.
  - start in RUN or DONE is ignored.
- DONE: `done` = 1 for exactly one cycle, then IDLE. `y` = 0.
- Unlimited mode (`match_limit` = 0): `match_count` wraps modulo 2^CW; runs until abort.
- Reset mid-RUN: immediate return to IDLE; count cleared; no done.
- `busy` = (state == RUN).
- start can be accepted again on the first IDLE cycle after DONE.

Decomposition:
- Shared package `seq_detect_pkg`:
  - state enum {S_IDLE, S_RUN, S_DONE}
  - default PW/LW/CW localparams
- Sub-module `seq_match_shreg`:
  - holds history (PW-1 bits) and fill counter
  - inputs: `shift`, `clr_fill`, `clear`, `x`, latched pattern/len
  - outputs: combinational `hit`
  - the controller FSM, counter and handshake outputs stay in the top.

Test Plan:
- Non-overlap: `pattern` = 4'b1001, `pat_len` = 4, `overlap` = 0, limit = 0; stream 1,0,0,1,0,0,1 → `y` high on bit 4 only; `match_count` = 1.
- Overlap: same stream with `overlap` = 1 → `y` on bits 4 and 7; `match_count` = 2.
- Limit and gaps: limit = 2, `pattern` = 2'b11, `pat_len` = 2, overlap; stream 1,1,1 with `x_valid` low every other cycle → `y` on the 2nd and 3rd valid bits; `done` one cycle later; `busy` falls; `match_count` = 2 held.
- Invalid config: start with `pat_len` = 0, then `pat_len` = 9 (PW = 8) → `err` pulses each time; state stays IDLE; `busy` = 0.
- Abort/reset priority: in RUN, assert `abort` on the cycle a match would occur → `y` = 0, count unchanged, IDLE. Repeat with `reset` instead → `match_count` = 0.
- Start-while-busy: start pulses in RUN with a different pattern → ignored; the original pattern is still detected.
